mmio_arbiter: RTL and testbench

- Shares the single MMIO peripheral port (0xFFFFFCxx space: seg, key, timers, PWM, watchdog, LED, switches) between two masters.
- M0 is the CPU data-memory port; M1 is the debug/loader engine.
- Sequences each access as a one-cycle slave transaction and returns read data registered.
- Parks the slave address on a neutral value when idle, so read-side-effect registers (timer flags clear on read) never see spurious reads.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_arbiter_rr_arb2.sv | 32 +++
 rtl/mmio_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mmio_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO port arbiter: register map, park address,
// arbiter state encoding and master indices.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE     = 32'hFFFF_FC00;
    localparam logic [7:0]  OFF_SEG       = 8'h00;
    localparam logic [7:0]  OFF_KEY       = 8'h10;
    localparam logic [7:0]  OFF_TMR0      = 8'h20;
    localparam logic [7:0]  OFF_TMR1      = 8'h30;
    localparam logic [7:0]  OFF_PWM       = 8'h40;
    localparam logic [7:0]  OFF_WDT       = 8'h50;
    localparam logic [7:0]  OFF_LED       = 8'h60;
    localparam logic [7:0]  OFF_SW        = 8'h70;

    // Must decode to no peripheral register so a parked bus never triggers read side effects.
    localparam logic [31:0] PARK_ADDR_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    function automatic logic [31:0] mmio_addr(input logic [7:0] off);
        return MMIO_BASE | {24'h00_0000, off};
    endfunction

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way combinational picker: round-robin on ties, or fixed M0 priority.
// The "last granted" pointer is owned by the caller.
module rr_arb2
    import mmio_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last,
    input  logic       fixed_prio,
    output logic [1:0] win,
    output logic       valid
);

    // On a tie the master that was not granted last wins, unless M0 has fixed priority.
    always_comb begin
        win = 2'b00;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11: begin
                if (fixed_prio || (last == M_DBG)) begin
                    win = 2'b01;
                end else begin
                    win = 2'b10;
                end
            end
            default: win = 2'b00;
        endcase
    end

    assign valid = |elig;

endmodule

// File: rtl/mmio_arbiter.sv
// Shares the MMIO peripheral port between the CPU (M0) and debug engine (M1) as one-cycle
// slave transactions. Optional atomic locking is enabled by defining MMIO_ARB_LOCK_EN.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  PARK_ADDR  = ADDR_W'(PARK_ADDR_DEF),
    parameter int                 FIXED_PRIO = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m_req,
    input  logic [1:0]            m_we,
    input  logic [7:0]            m_be,
    input  logic [2*ADDR_W-1:0]   m_addr,
    input  logic [2*DATA_W-1:0]   m_wdata,
`ifdef MMIO_ARB_LOCK_EN
    input  logic [1:0]            m_lock,
    output logic                  locked,
`endif
    output logic [1:0]            m_gnt,
    output logic [1:0]            m_rvalid,
    output logic [DATA_W-1:0]     m_rdata,
    output logic                  s_we,
    output logic [3:0]            s_be,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic                  busy
);

    arb_state_e           state_r;
    logic [1:0]           gnt_r;
    logic [1:0]           rvalid_r;
    logic [DATA_W-1:0]    rdata_r;
    logic                 s_we_r;
    logic [3:0]           s_be_r;
    logic [ADDR_W-1:0]    s_addr_r;
    logic [DATA_W-1:0]    s_wdata_r;
    logic                 rr_last_r;

    logic [1:0]           lock_mask_s;
    logic [1:0]           elig_s;
    logic [1:0]           win_s;
    logic                 valid_s;
    logic                 win_idx_s;
    logic                 sel_we_s;
    logic [3:0]           sel_be_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_wdata_s;
    logic                 fixed_prio_s;

    assign fixed_prio_s = (FIXED_PRIO != 0);

`ifdef MMIO_ARB_LOCK_EN
    logic                 locked_r;
    logic                 lock_owner_r;

    // While locked only the lock holder may be chosen.
    always_comb begin
        if (locked_r) begin
            lock_mask_s = (lock_owner_r == M_DBG) ? 2'b10 : 2'b01;
        end else begin
            lock_mask_s = 2'b11;
        end
    end

    // Lock state follows the m_lock bit of every granted transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked_r     <= 1'b0;
            lock_owner_r <= M_CPU;
        end else if (valid_s) begin
            locked_r     <= m_lock[win_idx_s];
            lock_owner_r <= win_idx_s;
        end else begin
            locked_r     <= locked_r;
            lock_owner_r <= lock_owner_r;
        end
    end

    assign locked = locked_r;
`else
    assign lock_mask_s = 2'b11;
`endif

    // The owner's request during its grant cycle is the one being served, so it is masked.
    assign elig_s = m_req & ~gnt_r & lock_mask_s;

    rr_arb2 u_pick (
        .elig       (elig_s),
        .last       (rr_last_r),
        .fixed_prio (fixed_prio_s),
        .win        (win_s),
        .valid      (valid_s)
    );

    assign win_idx_s = win_s[1];

    // Select the winning master's transaction fields.
    always_comb begin
        if (win_idx_s == M_DBG) begin
            sel_we_s    = m_we[1];
            sel_be_s    = m_be[7:4];
            sel_addr_s  = m_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = m_wdata[2*DATA_W-1:DATA_W];
        end else begin
            sel_we_s    = m_we[0];
            sel_be_s    = m_be[3:0];
            sel_addr_s  = m_addr[ADDR_W-1:0];
            sel_wdata_s = m_wdata[DATA_W-1:0];
        end
    end

    // Arbiter FSM: decides the next owner every cycle and registers all slave/master outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            gnt_r     <= 2'b00;
            rvalid_r  <= 2'b00;
            rdata_r   <= '0;
            s_we_r    <= 1'b0;
            s_be_r    <= 4'h0;
            s_addr_r  <= PARK_ADDR;
            s_wdata_r <= '0;
            rr_last_r <= M_DBG;
        end else begin
            if ((state_r == ACCESS) && !s_we_r) begin
                rvalid_r <= gnt_r;
                rdata_r  <= s_rdata;
            end else begin
                rvalid_r <= 2'b00;
                rdata_r  <= rdata_r;
            end

            if (valid_s) begin
                state_r   <= ACCESS;
                gnt_r     <= win_s;
                s_we_r    <= sel_we_s;
                s_be_r    <= sel_be_s;
                s_addr_r  <= sel_addr_s;
                s_wdata_r <= sel_wdata_s;
                rr_last_r <= win_idx_s;
            end else begin
                state_r   <= IDLE;
                gnt_r     <= 2'b00;
                s_we_r    <= 1'b0;
                s_be_r    <= 4'h0;
                s_addr_r  <= PARK_ADDR;
                s_wdata_r <= s_wdata_r;
                rr_last_r <= rr_last_r;
            end
        end
    end

    assign m_gnt    = gnt_r;
    assign m_rvalid = rvalid_r;
    assign m_rdata  = rdata_r;
    assign s_we     = s_we_r;
    assign s_be     = s_be_r;
    assign s_addr   = s_addr_r;
    assign s_wdata  = s_wdata_r;
    assign busy     = (state_r == ACCESS);

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: transaction-level model compared every cycle,
// plus directed literal checks. Lock scenario runs when MMIO_ARB_LOCK_EN is defined.
module tb_mmio_arbiter;

    localparam int FP = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_req   = 2'b00;
    logic [1:0]  m_we    = 2'b00;
    logic [7:0]  m_be    = 8'h00;
    logic [63:0] m_addr  = 64'h0;
    logic [63:0] m_wdata = 64'h0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  m_gnt, m_rvalid;
    logic [31:0] m_rdata, s_addr, s_wdata;
    logic        s_we, busy;
    logic [3:0]  s_be;
`ifdef MMIO_ARB_LOCK_EN
    logic [1:0]  m_lock = 2'b00;
    logic        locked;
`endif

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    mmio_arbiter #(.FIXED_PRIO(FP)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata),
`ifdef MMIO_ARB_LOCK_EN
        .m_lock(m_lock), .locked(locked),
`endif
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .s_we(s_we), .s_be(s_be),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    // ---------------- transaction-level model ----------------
    int          cur;      // master owning the slave this cycle, -1 when parked
    int          last_w;
    bit          lk_on;
    int          lk_own;
    logic [1:0]  exp_gnt, exp_rvalid;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;

    always @(posedge clk or negedge rst) begin : model
        bit e0, e1;
        int w;
        if (!rst) begin
            cur <= -1; last_w <= 1; lk_on <= 1'b0; lk_own <= 0;
            exp_gnt <= 2'b00; exp_rvalid <= 2'b00; exp_rdata <= 32'h0;
            exp_we <= 1'b0; exp_be <= 4'h0; exp_addr <= 32'h0; exp_wdata <= 32'h0;
        end else begin
            if (cur >= 0 && !exp_we) begin
                exp_rvalid <= onehot(cur);
                exp_rdata  <= s_rdata;
            end else begin
                exp_rvalid <= 2'b00;
            end
            e0 = m_req[0] && (cur != 0) && !(lk_on && lk_own != 0);
            e1 = m_req[1] && (cur != 1) && !(lk_on && lk_own != 1);
            if (e0 && e1)  w = (FP != 0) ? 0 : ((last_w == 0) ? 1 : 0);
            else if (e0)   w = 0;
            else if (e1)   w = 1;
            else           w = -1;
            cur <= w;
            if (w >= 0) begin
                last_w    <= w;
                exp_gnt   <= onehot(w);
                exp_we    <= m_we[w];
                exp_be    <= m_be[w*4 +: 4];
                exp_addr  <= m_addr[w*32 +: 32];
                exp_wdata <= m_wdata[w*32 +: 32];
`ifdef MMIO_ARB_LOCK_EN
                lk_on     <= m_lock[w];
                lk_own    <= w;
`endif
            end else begin
                exp_gnt <= 2'b00; exp_we <= 1'b0; exp_be <= 4'h0; exp_addr <= 32'h0;
            end
        end
    end

    // Compare every output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            chk("gnt",     {30'h0, m_gnt},    {30'h0, exp_gnt});
            chk("rvalid",  {30'h0, m_rvalid}, {30'h0, exp_rvalid});
            chk("rdata",   m_rdata,           exp_rdata);
            chk("s_we",    {31'h0, s_we},     {31'h0, exp_we});
            chk("s_be",    {28'h0, s_be},     {28'h0, exp_be});
            chk("s_addr",  s_addr,            exp_addr);
            chk("s_wdata", s_wdata,           exp_wdata);
            chk("busy",    {31'h0, busy},     {31'h0, (cur >= 0)});
`ifdef MMIO_ARB_LOCK_EN
            chk("locked",  {31'h0, locked},   {31'h0, lk_on});
`endif
        end
    end

    task automatic set_m(input int i, input bit r, input bit we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
        m_req[i]          = r;
        m_we[i]           = we;
        m_be[i*4 +: 4]    = be;
        m_addr[i*32 +: 32]  = a;
        m_wdata[i*32 +: 32] = d;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    logic [1:0] alt_exp [6];

    initial begin
        alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        run = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_gnt",    {30'h0, m_gnt},    32'h0);
        chk("rst_s_addr", s_addr,            32'h0);
        chk("rst_busy",   {31'h0, busy},     32'h0);
        cycles(2);
        rst = 1'b1;
        cycles(2);

        // M0 single write to LED
        set_m(0, 1'b1, 1'b1, 4'hF, 32'hFFFF_FC60, 32'h00A5_A5A5);
        @(negedge clk);
        chk("wr_gnt",    {30'h0, m_gnt}, 32'h1);
        chk("wr_s_we",   {31'h0, s_we},  32'h1);
        chk("wr_s_addr", s_addr,         32'hFFFF_FC60);
        chk("wr_wdata",  s_wdata,        32'h00A5_A5A5);
        m_req[0] = 1'b0;
        @(negedge clk);
        chk("wr_rvalid", {30'h0, m_rvalid}, 32'h0);
        chk("wr_park",   s_addr,            32'h0);

        // M1 read of switches
        set_m(1, 1'b1, 1'b0, 4'hF, 32'hFFFF_FC70, 32'h0);
        s_rdata = 32'h0012_3456;
        @(negedge clk);
        chk("rd_gnt",    {30'h0, m_gnt}, 32'h2);
        chk("rd_s_addr", s_addr,         32'hFFFF_FC70);
        m_req[1] = 1'b0;
        @(negedge clk);
        chk("rd_rvalid", {30'h0, m_rvalid}, 32'h2);
        chk("rd_rdata",  m_rdata,           32'h0012_3456);
        chk("rd_park",   s_addr,            32'h0);
        s_rdata = 32'h0;
        cycles(1);

        // Both masters requesting continuously: alternate with no idle cycle
        set_m(0, 1'b1, 1'b1, 4'h3, 32'hFFFF_FC10, 32'h0000_0011);
        set_m(1, 1'b1, 1'b0, 4'hF, 32'hFFFF_FC50, 32'h0);
        s_rdata = 32'hCAFE_0050;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("alt_gnt", {30'h0, m_gnt}, {30'h0, alt_exp[k]});
        end
        m_req = 2'b00;
        cycles(2);

        // After an M0 grant, a tie goes to M1 under round-robin
        set_m(0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FC30, 32'h0);
        s_rdata = 32'h0000_0BEE;
        @(negedge clk);
        m_req[0] = 1'b0;
        cycles(2);
        set_m(0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FC00, 32'h0);
        set_m(1, 1'b1, 1'b1, 4'h1, 32'hFFFF_FC40, 32'h0000_0077);
        @(negedge clk);
        chk("tie_gnt", {30'h0, m_gnt}, (FP != 0) ? 32'h1 : 32'h2);
        m_req = 2'b00;
        cycles(2);

        // Idle: slave stays parked
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_s_addr", s_addr,        32'h0);
            chk("idle_s_we",   {31'h0, s_we}, 32'h0);
        end

        // Reset in the middle of a read access
        set_m(1, 1'b1, 1'b0, 4'hF, 32'hFFFF_FC20, 32'h0);
        s_rdata = 32'h0000_0001;
        @(negedge clk);
        chk("mid_gnt", {30'h0, m_gnt}, 32'h2);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_gnt",  {30'h0, m_gnt}, 32'h0);
        chk("mid_rst_addr", s_addr,         32'h0);
        chk("mid_rst_busy", {31'h0, busy},  32'h0);
        m_req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rvalid", {30'h0, m_rvalid}, 32'h0);
        end

`ifdef MMIO_ARB_LOCK_EN
        // M0 locked read then unlocked write; M1 must wait for the unlock
        set_m(0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FC00, 32'h0);
        m_lock = 2'b01;
        set_m(1, 1'b1, 1'b1, 4'hF, 32'hFFFF_FC40, 32'h0000_0099);
        s_rdata = 32'h0000_00AA;
        @(negedge clk);
        chk("lk1_gnt", {30'h0, m_gnt}, 32'h1);
        chk("lk1_locked", {31'h0, locked}, 32'h1);
        set_m(0, 1'b1, 1'b1, 4'hF, 32'hFFFF_FC00, 32'h0000_00AB);
        m_lock = 2'b00;
        @(negedge clk);
        chk("lk2_gnt", {30'h0, m_gnt}, 32'h0);
        chk("lk2_locked", {31'h0, locked}, 32'h1);
        @(negedge clk);
        chk("lk3_gnt", {30'h0, m_gnt}, 32'h1);
        chk("lk3_s_we", {31'h0, s_we}, 32'h1);
        chk("lk3_locked", {31'h0, locked}, 32'h0);
        m_req[0] = 1'b0;
        @(negedge clk);
        chk("lk4_gnt", {30'h0, m_gnt}, 32'h2);
        m_req = 2'b00;
        cycles(2);
`endif

        cycles(2);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
